alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares the single-cycle combinational ALU between two requesters (e.g. the datapath issue port and a debug/test port), with round-robin fairness.
- Each request has a valid/ready handshake. The block latches the operands, drives the ALU for one cycle, registers the result, and returns it on one shared response channel with backpressure.
- Sits between the requesters and the ALU instance; the ALU itself is unchanged.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU data width.
- OPW, 4, ALU opcode width.
- CNTW, 16, width of the completed-operation counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_a  input  WIDTH  requester 0 operand a.
- req0_b  input  WIDTH  requester 0 operand b.
- req0_op  input  OPW  requester 0 ALU opcode.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req1_valid, req1_a, req1_b, req1_op, req1_ready: same as requester 0, for requester 1.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts the result.
- resp_id  output  1  requester that owns the result.
- resp_data  output  WIDTH  registered ALU result.
- resp_zero  output  1  registered ALU zero flag.
- alu_a  output  WIDTH  registered operand a to the ALU.
- alu_b  output  WIDTH  registered operand b to the ALU.
- alu_op  output  OPW  registered opcode to the ALU.
- alu_out  input  WIDTH  ALU combinational result.
- alu_zero  input  1  ALU combinational zero flag.
- busy  output  1  high in any state other than IDLE.
- ops_done  output  CNTW  count of completed response handshakes.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state returns to IDLE; last_grant=1, so requester 0 wins the first tie.
  - alu_a, alu_b, alu_op, resp_data, resp_zero, resp_id and ops_done clear to 0.
  - resp_valid=0, busy=0, req0_ready=0, req1_ready=0.
  - Reset mid-transaction discards it; no response is produced.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant rule: if exactly one reqX_valid is high, grant that requester. If both are high, grant the requester not equal to last_grant.
  - reqX_ready is combinational and goes high only for the granted requester, only in IDLE. At most one ready is high per cycle.
  - On the edge ending the grant cycle: latch that requester's a/b/op into alu_a/alu_b/alu_op, store resp_id=granted index and last_grant=granted index, then go to EXEC.
  - With no request pending, stay in IDLE.
- EXEC:
  - The ALU sees stable registered inputs for the full cycle.
  - At the edge: resp_data<=alu_out, resp_zero<=alu_zero, go to RESP. No requester handshake happens in this state.
- RESP:
  - resp_valid=1, and resp_data, resp_zero and resp_id are held stable until resp_ready=1.
  - On the handshake edge: ops_done increments (wraps at 2^CNTW), go to IDLE.
  - resp_ready while resp_valid=0 is ignored.
- Timing:
  - Accept in cycle N gives resp_valid in cycle N+2.
  - Peak throughput is one operation per 3 cycles.
  - A new grant can occur in the cycle after a response handshake.
- Requester obligations: hold valid and operands stable until ready. The arbiter never drops or reorders an accepted operation.
- Opcodes pass through unchanged:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0101 slt, 0110 sll.
  - Undefined opcodes produce whatever the ALU returns (0 with zero=1) and still complete normally.
- alu_a, alu_b and alu_op keep their last values outside EXEC. They change only on grant.

Test Plan:
- Reset, then req0: a=5, b=3, op=0000 -> req0_ready high one cycle; 2 cycles later resp_valid=1, resp_data=8, resp_zero=0, resp_id=0; ops_done=1 after the handshake.
- Both valid from reset: req0 sub 7-7, req1 or 0xF0|0x0F; resp_ready=1 -> req0 is served first (data 0, zero=1), then req1 (data 0xFF, id 1). Keep both valid for 4 ops -> grants alternate 0,1,0,1.
- Backpressure: req1 slt a=2, b=9; hold resp_ready=0 for 5 cycles -> resp_valid, data=1 and id=1 stay stable; req0_valid during the stall gets no ready until 1 cycle after the handshake.
- Shift and illegal opcode: req0 a=1, b=4, op=0110 -> resp_data=16. Then op=0111 -> resp_data=0, resp_zero=1, normal completion.
- Reset mid-operation: assert rst in EXEC -> next cycle IDLE, resp_valid=0, ops_done=0, no response emitted. A subsequent tie is granted to req0.
- Counter wrap: with CNTW=2, complete 5 operations -> ops_done reads 1.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester, response and ALU-side signal bundle for alu_arbiter
//
// Groups the two requester channels, the shared response channel and the
// ALU operand/result wires. The arbiter connects through the slave modport;
// the environment (requesters, consumer, ALU) connects through master.
interface alu_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [OPW-1:0]   req0_op;
    logic             req0_ready;

    logic             req1_valid;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [OPW-1:0]   req1_op;
    logic             req1_ready;

    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic [WIDTH-1:0] resp_data;
    logic             resp_zero;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_out;
    logic             alu_zero;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output resp_valid, resp_id, resp_data, resp_zero,
        input  resp_ready,
        output alu_a, alu_b, alu_op,
        input  alu_out, alu_zero
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  resp_valid, resp_id, resp_data, resp_zero,
        output resp_ready,
        input  alu_a, alu_b, alu_op,
        output alu_out, alu_zero
    );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one combinational ALU between two requesters
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   bus       alu_arbiter_if.slave: req0/req1 valid/ready channels with a/b/op,
//             shared resp_valid/resp_ready channel with resp_id/resp_data/resp_zero,
//             registered alu_a/alu_b/alu_op out to the ALU, alu_out/alu_zero back
//   busy      high whenever an operation is in flight (not IDLE)
//   ops_done  count of completed response handshakes, wraps at 2^CNTW
//
// One operation at a time: IDLE (grant + latch operands) -> EXEC (ALU sees
// registered operands, result captured) -> RESP (held until resp_ready).
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4,
    parameter int CNTW  = 16
) (
    input  logic            clk,
    input  logic            rst,
    alu_arbiter_if.slave    bus,
    output logic            busy,
    output logic [CNTW-1:0] ops_done
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    logic             last_grant_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [OPW-1:0]   alu_op_q;
    logic [WIDTH-1:0] resp_data_q;
    logic             resp_zero_q;
    logic             resp_id_q;
    logic [CNTW-1:0]  ops_done_q;
    logic [CNTW-1:0]  ops_done_d;

    logic             any_req;
    logic             gnt_idx;
    logic             gnt_fire;

    // On a tie the requester that did not win last time is chosen; with a
    // single request the requester index is simply req1_valid.
    assign any_req  = bus.req0_valid | bus.req1_valid;
    assign gnt_idx  = (bus.req0_valid & bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
    assign gnt_fire = (state_q == IDLE) & any_req;

    assign bus.req0_ready = gnt_fire & ~gnt_idx;
    assign bus.req1_ready = gnt_fire &  gnt_idx;

    assign ops_done_d = ops_done_q + CNTW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            resp_data_q  <= '0;
            resp_zero_q  <= 1'b0;
            resp_id_q    <= 1'b0;
            ops_done_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        alu_a_q      <= gnt_idx ? bus.req1_a  : bus.req0_a;
                        alu_b_q      <= gnt_idx ? bus.req1_b  : bus.req0_b;
                        alu_op_q     <= gnt_idx ? bus.req1_op : bus.req0_op;
                        resp_id_q    <= gnt_idx;
                        last_grant_q <= gnt_idx;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    resp_data_q <= bus.alu_out;
                    resp_zero_q <= bus.alu_zero;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        ops_done_q <= ops_done_d;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_zero  = resp_zero_q;
    assign bus.resp_id    = resp_id_q;
    assign busy           = (state_q != IDLE);
    assign ops_done       = ops_done_q;
endmodule
